sdram_wbuf: RTL

SDRAM_WBUF -- requirements
Module: sdram_wbuf

---
 rtl/sdram_wbuf.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sdram_wbuf.sv
// sdram_wbuf: posted-write buffer in front of a single SDRAM port.
// CPU writes are queued in a small FIFO and drained in order; a CPU read
// stalls the CPU until every earlier write has reached the SDRAM and the
// read data has come back.
module sdram_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [24:1]  cpu_addr,
  input  logic [15:0]  cpu_din,
  input  logic         cpu_rd,
  input  logic         cpu_wrl,
  input  logic         cpu_wrh,
  output logic [15:0]  cpu_dout,
  output logic         cpu_rdy,
  output logic         cpu_busy,
  output logic [24:1]  ram_addr,
  output logic [15:0]  ram_din,
  output logic         ram_rd,
  output logic         ram_wrl,
  output logic         ram_wrh,
  input  logic [15:0]  ram_dout,
  input  logic         ram_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t state, state_nx;

  logic [24:1]   fifo_addr [DEPTH];
  logic [15:0]   fifo_data [DEPTH];
  logic [1:0]    fifo_mask [DEPTH];   // {wrh, wrl}
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic          rd_pend;
  logic [24:1]   rd_addr;
  logic          cur_is_rd;

  logic fifo_full, fifo_empty, wr_stb, push, pop, rd_acc;
  logic start_wr, start_rd, done, rd_done;

  // Strobe acceptance and sequencing qualifiers.
  always_comb begin
    fifo_full  = (count == CW'(DEPTH));
    fifo_empty = (count == '0);
    cpu_busy   = fifo_full | rd_pend;
    wr_stb     = cpu_wrl | cpu_wrh;
    push       = !cpu_busy && wr_stb;
    // A read strobe coinciding with a write strobe is dropped.
    rd_acc     = !cpu_busy && cpu_rd && !wr_stb;
    start_wr   = (state == IDLE) && !ram_busy && !fifo_empty;
    start_rd   = (state == IDLE) && !ram_busy && fifo_empty && rd_pend;
    done       = (state == WAIT) && !ram_busy;
    pop        = done && !cur_is_rd;
    rd_done    = done && cur_is_rd;
  end

  // FIFO storage; entries are only meaningful between wptr and rptr.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= cpu_addr;
      fifo_data[wptr] <= cpu_din;
      fifo_mask[wptr] <= {cpu_wrh, cpu_wrl};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Pending read: address latched on acceptance, cleared as cpu_rdy fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else if (rd_acc) begin
      rd_pend <= 1'b1;
      rd_addr <= cpu_addr;
    end else if (rd_done) begin
      rd_pend <= 1'b0;
    end
  end

  // SDRAM port sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // SDRAM port sequencer next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_wr || start_rd) state_nx = ISSUE;
      ISSUE:   if (ram_busy)             state_nx = WAIT;
      WAIT:    if (!ram_busy)            state_nx = GAP;
      GAP:                               state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Registered SDRAM request/address/data and CPU read return.
  // Requests are raised on the IDLE->ISSUE edge and dropped on WAIT->GAP,
  // so address/data/mask stay frozen for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_rd    <= 1'b0;
      ram_wrl   <= 1'b0;
      ram_wrh   <= 1'b0;
      cur_is_rd <= 1'b0;
      cpu_rdy   <= 1'b0;
      cpu_dout  <= '0;
    end else begin
      cpu_rdy <= 1'b0;
      if (start_wr) begin
        ram_addr           <= fifo_addr[rptr];
        ram_din            <= fifo_data[rptr];
        {ram_wrh, ram_wrl} <= fifo_mask[rptr];
        ram_rd             <= 1'b0;
        cur_is_rd          <= 1'b0;
      end else if (start_rd) begin
        ram_addr  <= rd_addr;
        ram_rd    <= 1'b1;
        ram_wrl   <= 1'b0;
        ram_wrh   <= 1'b0;
        cur_is_rd <= 1'b1;
      end
      if (done) begin
        ram_rd  <= 1'b0;
        ram_wrl <= 1'b0;
        ram_wrh <= 1'b0;
        if (cur_is_rd) begin
          cpu_dout <= ram_dout;
          cpu_rdy  <= 1'b1;
        end
      end
    end
  end

endmodule
